// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the I/D memory request arbiter.
package mem_arb_pkg;

  localparam int unsigned AddrWidthDef = 64;
  localparam int unsigned ClWidthDef   = 512;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdGo   = 3'd1,
    StRdWait = 3'd2,
    StRdPop  = 3'd3,
    StWrGo   = 3'd4,
    StWrPush = 3'd5,
    StWrWait = 3'd6,
    StResp   = 3'd7
  } arb_state_t;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } owner_t;

  // States in which the transaction waits on the DMA engine.
  function automatic logic is_wait(arb_state_t s);
    return (s == StRdWait) || (s == StWrPush) || (s == StWrWait);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; bit 0 = I side, bit 1 = D side.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  owner_t last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == OwnI) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OwnI;
    end else if (upd_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1] ? OwnD : OwnI;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one DMA line channel between I fills and D fills/writebacks.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AddrWidthDef,
  parameter int unsigned CL_WIDTH       = ClWidthDef,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rsp_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [CL_WIDTH-1:0]   d_wr_data,
  output logic                  d_gnt,
  output logic                  d_rsp_valid,
  output logic [CL_WIDTH-1:0]   rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  output logic                  dma_rd_en,
  output logic                  dma_wr_en,
  output logic [CL_WIDTH-1:0]   dma_wr_data,
  input  logic [CL_WIDTH-1:0]   dma_rd_data,
  input  logic                  dma_empty,
  input  logic                  dma_full,
  input  logic                  dma_wr_done,
  output logic                  busy,
  output logic                  timeout_err
);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CL_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CL_WIDTH-1:0]   rsp_data_q;
  logic                  i_gnt_q, d_gnt_q, i_rsp_q, d_rsp_q;
  logic                  rd_go_q, wr_go_q, rd_en_q, wr_en_q, busy_q;
  logic                  capture, wd_expired;
  logic [1:0]            arb_gnt;

  assign capture = (state_q == StIdle) && (i_req || d_req);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({d_req, i_req}),
    .upd_i (capture),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (capture) begin
          owner_d = arb_gnt[1] ? OwnD : OwnI;
          addr_d  = arb_gnt[1] ? d_addr : i_addr;
          if (arb_gnt[1]) wdata_d = d_wr_data;
          state_d = (arb_gnt[1] && d_we) ? StWrGo : StRdGo;
        end
      end
      StRdGo:   state_d = StRdWait;
      StRdWait: begin
        if (wd_expired)      state_d = StResp;
        else if (!dma_empty) state_d = StRdPop;
      end
      StRdPop:  state_d = StResp;
      StWrGo:   state_d = StWrPush;
      // The push strobe is issued from this state; leave once it has gone out.
      StWrPush: begin
        if (wd_expired)   state_d = StResp;
        else if (wr_en_q) state_d = StWrWait;
      end
      StWrWait: begin
        if (wd_expired)       state_d = StResp;
        else if (dma_wr_done) state_d = StResp;
      end
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= OwnI;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rsp_q    <= 1'b0;
      d_rsp_q    <= 1'b0;
      rd_go_q    <= 1'b0;
      wr_go_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == StRdPop) rsp_data_q <= dma_rd_data;
      i_gnt_q <= ((state_d == StRdGo) || (state_d == StWrGo)) && (owner_d == OwnI);
      d_gnt_q <= ((state_d == StRdGo) || (state_d == StWrGo)) && (owner_d == OwnD);
      i_rsp_q <= (state_d == StResp) && (owner_d == OwnI);
      d_rsp_q <= (state_d == StResp) && (owner_d == OwnD);
      rd_go_q <= (state_d == StRdGo);
      wr_go_q <= (state_d == StWrGo);
      rd_en_q <= (state_d == StRdPop);
      wr_en_q <= (state_d == StWrPush) && !dma_full && !wr_en_q;
      busy_q  <= (state_d != StIdle);
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] WdLimit = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;
  logic        rsp_err_q, timeout_err_q;

  always_comb begin
    wd_d = wd_q;
    if (is_wait(state_d) && (state_d != state_q)) wd_d = '0;
    else if (is_wait(state_q))                    wd_d = wd_q + 16'd1;
  end

  assign wd_expired = is_wait(state_q) && (wd_q == WdLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q          <= '0;
      rsp_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      rsp_err_q     <= wd_expired;
      timeout_err_q <= timeout_err_q | wd_expired;
    end
  end

  assign rsp_err     = rsp_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign wd_expired  = 1'b0;
  assign rsp_err     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign i_gnt       = i_gnt_q;
  assign d_gnt       = d_gnt_q;
  assign i_rsp_valid = i_rsp_q;
  assign d_rsp_valid = d_rsp_q;
  assign rsp_data    = rsp_data_q;
  assign dma_addr    = addr_q;
  assign dma_wr_data = wdata_q;
  assign dma_rd_go   = rd_go_q;
  assign dma_wr_go   = wr_go_q;
  assign dma_rd_en   = rd_en_q;
  assign dma_wr_en   = wr_en_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: fills, writebacks, arbitration, reset, watchdog.
module tb_mem_req_arbiter;

  localparam int AW = 64;
  localparam int CW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [CW-1:0] d_wr_data = '0, dma_rd_data = '0;
  logic          dma_empty = 1'b1, dma_full = 1'b0, dma_wr_done = 1'b0;
  logic          i_gnt, i_rsp_valid, d_gnt, d_rsp_valid, rsp_err;
  logic          dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en, busy, timeout_err;
  logic [CW-1:0] rsp_data, dma_wr_data;
  logic [AW-1:0] dma_addr;
  logic [10:0]   ctl_out;

  int checks = 0;
  int failures = 0;

  mem_req_arbiter #(
    .ADDR_WIDTH     (AW),
    .CL_WIDTH       (CW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_rsp_valid (i_rsp_valid),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wr_data   (d_wr_data),
    .d_gnt       (d_gnt),
    .d_rsp_valid (d_rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .dma_addr    (dma_addr),
    .dma_rd_go   (dma_rd_go),
    .dma_wr_go   (dma_wr_go),
    .dma_rd_en   (dma_rd_en),
    .dma_wr_en   (dma_wr_en),
    .dma_wr_data (dma_wr_data),
    .dma_rd_data (dma_rd_data),
    .dma_empty   (dma_empty),
    .dma_full    (dma_full),
    .dma_wr_done (dma_wr_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  assign ctl_out = {i_gnt, i_rsp_valid, d_gnt, d_rsp_valid, rsp_err, dma_rd_go, dma_wr_go,
                    dma_rd_en, dma_wr_en, busy, timeout_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ctl_out !== 11'd0) begin
      failures++;
      $display("FAIL reset_ctl: got %b expected 0", ctl_out);
    end
    checks++;
    if (dma_addr !== '0 || rsp_data !== '0 || dma_wr_data !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr %0h rsp %0h wd %0h expected 0", dma_addr, rsp_data,
               dma_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_contention();
    int            ng = 0;
    int            gc[4];
    logic          got_d[4];
    logic [AW-1:0] ga[4];
    logic          both = 1'b0;
    dma_empty = 1'b0;
    d_we = 1'b0;
    i_addr = 64'h3000;
    d_addr = 64'h4000;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 1; c <= 40 && ng < 4; c++) begin
      step();
      if (i_gnt && d_gnt) both = 1'b1;
      if (i_gnt || d_gnt) begin
        gc[ng] = c;
        got_d[ng] = d_gnt;
        ga[ng] = dma_addr;
        ng++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (ng !== 4 || both) begin
      failures++;
      $display("FAIL cont_grants: got %0d grants (dual=%b) expected 4 single", ng, both);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_d[k] !== ((k % 2) == 0)) begin
          failures++;
          $display("FAIL cont_owner%0d: got d=%b expected d=%b", k, got_d[k], (k % 2) == 0);
        end
        checks++;
        if (ga[k] !== (((k % 2) == 0) ? 64'h4000 : 64'h3000)) begin
          failures++;
          $display("FAIL cont_addr%0d: got %0h", k, ga[k]);
        end
      end
      checks++;
      if (gc[0] !== 1 || gc[1] !== 6) begin
        failures++;
        $display("FAIL cont_timing: got grants at %0d,%0d expected 1,6", gc[0], gc[1]);
      end
    end
    repeat (6) step();
    dma_empty = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_i_fill();
    int            n_gnt = 0, n_go = 0, n_en = 0, n_rsp = 0, n_d = 0;
    int            c_go = -1, c_en = -1, c_rsp = -1;
    logic [AW-1:0] got_addr = '0;
    logic [CW-1:0] got_data = '0;
    dma_empty = 1'b1;
    dma_rd_data = {64{8'hA5}};
    step();
    i_req = 1'b1;
    i_addr = 64'h1000;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (i_gnt) begin n_gnt++; i_req = 1'b0; end
      if (dma_rd_go) begin n_go++; c_go = c; got_addr = dma_addr; end
      if (dma_rd_en) begin n_en++; c_en = c; end
      if (i_rsp_valid) begin n_rsp++; c_rsp = c; got_data = rsp_data; end
      if (d_gnt || d_rsp_valid || dma_wr_go || dma_wr_en) n_d++;
      dma_empty = !(c == 4 || c == 5);
    end
    checks++;
    if (n_gnt !== 1 || n_go !== 1 || c_go !== 1) begin
      failures++;
      $display("FAIL ifill_go: got gnt=%0d go=%0d at %0d expected 1,1 at 1", n_gnt, n_go, c_go);
    end
    checks++;
    if (got_addr !== 64'h1000) begin
      failures++;
      $display("FAIL ifill_addr: got %0h expected 1000", got_addr);
    end
    checks++;
    if (n_en !== 1 || c_en !== 5) begin
      failures++;
      $display("FAIL ifill_rden: got %0d at %0d expected 1 at 5", n_en, c_en);
    end
    checks++;
    if (n_rsp !== 1 || c_rsp !== 6 || got_data !== {64{8'hA5}}) begin
      failures++;
      $display("FAIL ifill_rsp: got %0d at %0d data %0h expected 1 at 6 data a5..", n_rsp,
               c_rsp, got_data);
    end
    checks++;
    if (n_d !== 0) begin
      failures++;
      $display("FAIL ifill_dside: got %0d d pulses expected 0", n_d);
    end
  endtask

  task automatic test_d_write();
    int            n_en = 0, n_rsp = 0, n_i = 0, c_go = -1, c_en = -1, c_rsp = -1;
    logic [CW-1:0] got_wd = '0;
    logic [AW-1:0] got_addr = '0;
    step();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 64'h2040;
    d_wr_data = {16{32'hDEADBEEF}};
    dma_full = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (d_gnt) d_req = 1'b0;
      if (dma_wr_go) begin c_go = c; got_addr = dma_addr; end
      if (dma_wr_en) begin n_en++; c_en = c; got_wd = dma_wr_data; end
      if (d_rsp_valid) begin n_rsp++; c_rsp = c; end
      if (i_gnt || i_rsp_valid || dma_rd_go || dma_rd_en) n_i++;
      dma_full = (c < 5);
      dma_wr_done = (c == 10);
    end
    dma_wr_done = 1'b0;
    checks++;
    if (c_go !== 1 || got_addr !== 64'h2040) begin
      failures++;
      $display("FAIL dwr_go: got cycle %0d addr %0h expected 1 2040", c_go, got_addr);
    end
    checks++;
    if (n_en !== 1 || c_en !== 6) begin
      failures++;
      $display("FAIL dwr_wren: got %0d at %0d expected 1 at 6", n_en, c_en);
    end
    checks++;
    if (got_wd !== {16{32'hDEADBEEF}}) begin
      failures++;
      $display("FAIL dwr_data: got %0h expected deadbeef..", got_wd);
    end
    checks++;
    if (n_rsp !== 1 || c_rsp !== 11 || n_i !== 0) begin
      failures++;
      $display("FAIL dwr_rsp: got %0d at %0d (i pulses %0d) expected 1 at 11", n_rsp, c_rsp, n_i);
    end
  endtask

  task automatic test_stale_done();
    int n_en = 0, n_rsp = 0, c_en = -1, c_rsp = -1;
    step();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 64'h2080;
    d_wr_data = {8{64'h0123456789ABCDEF}};
    dma_full = 1'b0;
    dma_wr_done = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (d_gnt) d_req = 1'b0;
      if (dma_wr_en) begin n_en++; c_en = c; end
      if (d_rsp_valid) begin n_rsp++; c_rsp = c; end
      dma_wr_done = (c <= 2) || (c == 6);
    end
    dma_wr_done = 1'b0;
    checks++;
    if (n_en !== 1 || c_en !== 2) begin
      failures++;
      $display("FAIL stale_wren: got %0d at %0d expected 1 at 2", n_en, c_en);
    end
    checks++;
    if (n_rsp !== 1 || c_rsp !== 7) begin
      failures++;
      $display("FAIL stale_rsp: got %0d at %0d expected 1 at 7", n_rsp, c_rsp);
    end
  endtask

  task automatic test_reset_mid_read();
    int   c_g = -1;
    logic first_d = 1'b0, first_i = 1'b0;
    dma_empty = 1'b1;
    step();
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 64'h5000;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (d_gnt) d_req = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl_out !== 11'd0) begin
      failures++;
      $display("FAIL rstmid_ctl: got %b expected 0", ctl_out);
    end
    checks++;
    if (dma_addr !== '0 || rsp_data !== '0) begin
      failures++;
      $display("FAIL rstmid_data: got addr %0h rsp %0h expected 0", dma_addr, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    dma_empty = 1'b0;
    i_addr = 64'h6000;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 1; c <= 5 && c_g < 0; c++) begin
      step();
      if (i_gnt || d_gnt) begin c_g = c; first_d = d_gnt; first_i = i_gnt; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (c_g !== 1 || first_d !== 1'b1 || first_i !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_tie: got cycle %0d d=%b i=%b expected 1 d=1 i=0", c_g, first_d,
               first_i);
    end
    repeat (8) step();
    dma_empty = 1'b1;
  endtask

  task automatic test_timeout();
    int n_rsp = 0, c_rsp = -1;
    logic err_at = 1'b0;
    dma_empty = 1'b1;
    step();
    i_req = 1'b1;
    i_addr = 64'h7000;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 30; c++) begin
      step();
      if (i_gnt) i_req = 1'b0;
      if (i_rsp_valid) begin n_rsp++; c_rsp = c; err_at = rsp_err; end
    end
    checks++;
    if (n_rsp !== 1 || c_rsp !== 18 || err_at !== 1'b1) begin
      failures++;
      $display("FAIL tmo_rsp: got %0d at %0d err %b expected 1 at 18 err 1", n_rsp, c_rsp,
               err_at);
    end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_sticky: got tmo %b busy %b expected 1 0", timeout_err, busy);
    end
`else
    for (int c = 1; c <= 1000; c++) begin
      step();
      if (i_gnt) i_req = 1'b0;
      if (i_rsp_valid || d_rsp_valid) n_rsp++;
      if (rsp_err || timeout_err) err_at = 1'b1;
    end
    checks++;
    if (n_rsp !== 0 || err_at !== 1'b0) begin
      failures++;
      $display("FAIL notmo_rsp: got %0d rsp err %b expected 0 0", n_rsp, err_at);
    end
    checks++;
    if (busy !== 1'b1 || dma_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL notmo_wait: got busy %b rd_en %b expected 1 0", busy, dma_rd_en);
    end
`endif
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_i_fill();
    test_d_write();
    test_stale_done();
    test_reset_mid_read();
    test_i_fill();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the single host DMA channel (one-line reads/writes, size 1) between the MMU's instruction-miss fill path and data-miss fill/writeback path. It sits between `MMU` and the DMA interface, and takes over the sequencing role `mem_ctrl` performs for a single requester. Each granted request runs to completion: go pulse, data pop or push, completion wait, then a one-cycle response to the owner. Two-way round-robin arbitration guarantees neither side starves.

## Interface
Parameters:
- ADDR_WIDTH, 64, virtual byte address width
- CL_WIDTH, 512, cache-line data width
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with MEM_ARB_TIMEOUT_EN

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction line-fill request; held with i_addr until i_gnt
- i_addr  in  ADDR_WIDTH  line-aligned fill address
- i_gnt  out  1  one-cycle grant pulse
- i_rsp_valid  out  1  one-cycle pulse: rsp_data holds the fill line
- d_req  in  1  data request; held with d_we/d_addr/d_wr_data until d_gnt
- d_we  in  1  1 = writeback, 0 = fill
- d_addr  in  ADDR_WIDTH  line-aligned address
- d_wr_data  in  CL_WIDTH  writeback line
- d_gnt  out  1  one-cycle grant pulse
- d_rsp_valid  out  1  one-cycle pulse: fill data valid, or write complete
- rsp_data  out  CL_WIDTH  last read line; held until next read capture
- rsp_err  out  1  qualifies *_rsp_valid; 1 = transaction timed out
- dma_addr  out  ADDR_WIDTH  drives dma.rd_addr and dma.wr_addr
- dma_rd_go, dma_wr_go  out  1  one-cycle start pulses
- dma_rd_en, dma_wr_en  out  1  one-cycle pop/push strobes
- dma_wr_data  out  CL_WIDTH  latched writeback line
- dma_rd_data  in  CL_WIDTH  show-ahead read data
- dma_empty, dma_full, dma_wr_done  in  1  DMA status
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, RD_GO, RD_WAIT, RD_POP, WR_GO, WR_PUSH, WR_WAIT, RESP.
- IDLE: if any request is present, the arbiter picks an owner. It latches the owner, address, we, and write data, then moves to RD_GO (I, or D with we=0) or WR_GO (D with we=1).
- Arbitration: round-robin on last_owner. With both requesting, the side not granted last wins. last_owner resets to I, so D wins the first tie.
- RD_GO: owner gnt=1, dma_rd_go=1, then RD_WAIT.
- RD_WAIT: when !dma_empty, go to RD_POP.
- RD_POP: dma_rd_en=1, rsp_data <= dma_rd_data, then RESP.
- WR_GO: d_gnt=1, dma_wr_go=1, then WR_PUSH.
- WR_PUSH: when !dma_full, dma_wr_en=1, then WR_WAIT. dma_wr_done is ignored before WR_WAIT, which masks stale done from the prior transfer.
- WR_WAIT: when dma_wr_done, go to RESP.
- RESP: owner rsp_valid=1, then IDLE.
- All outputs are registered. dma_addr and dma_wr_data are stable from the GO state through RESP.

## Timing
- Reset values:
  - all pulses, busy, rsp_err, and timeout_err are 0
  - rsp_data, dma_addr, and dma_wr_data are 0
  - state is IDLE; last_owner is I
- Read, best case (request seen in IDLE at cycle 0, DMA non-empty at cycle 2):
  - gnt and rd_go at cycle 1
  - rd_en at cycle 3
  - rsp_valid at cycle 4
  - IDLE at cycle 5; the next grant can be no earlier than cycle 6
- Write, best case (not full): gnt and wr_go at cycle 1, wr_en at cycle 2, then WR_WAIT for dma_wr_done, then RESP the cycle after done.
- A requester that drops req before its grant is simply not served. No request is captured while busy.
- If rst_n asserts mid-transaction, everything clears asynchronously. The transaction is abandoned and no response is issued.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to RD_WAIT, WR_PUSH, or WR_WAIT and increments every cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with rsp_err=1 and sets timeout_err.
  - timeout_err stays set until reset.
- Undefined: no counter; the FSM waits indefinitely; rsp_err and timeout_err are tied to 0.

## Structure
- The `mem_arb_pkg` package holds:
  - the ADDR_WIDTH and CL_WIDTH defaults
  - `arb_state_t` (the FSM state enum)
  - `owner_t` (I, D)
- Sub-module `rr_arb2`: two-request round-robin arbiter. It takes req[1:0] and an update strobe, and outputs a one-hot grant; last_owner lives inside it.
- FSM, latches, and watchdog stay in the top module.

## Test plan
- Single I fill: i_req, i_addr=0x1000, DMA empty drops 3 cycles after go, rd_data=0xA5.. → i_gnt one pulse, dma_addr=0x1000, one rd_en, rsp_data=0xA5.., i_rsp_valid one pulse, no d_* pulses.
- D writeback under back-pressure: d_we=1, d_addr=0x2040, dma_full held 5 cycles, wr_done 4 cycles after push → exactly one wr_en after full drops, wr_data matches, d_rsp_valid the cycle after wr_done.
- Contention: i_req and d_req held continuously for 4 transactions → grants D, I, D, I with no back-to-back same owner.
- Stale done: dma_wr_done high at wr_go → FSM still waits for push and then for done in WR_WAIT; no early response.
- Reset mid-read: rst_n low in RD_WAIT → all outputs 0 immediately; after release, an I request completes normally and the first tie goes to D.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): dma_empty stuck at 1 → rsp_valid with rsp_err=1 at the 16th wait cycle, timeout_err stays 1; without the macro → no response after 1000 cycles.
